// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one FIFO write port among NREQ
// requesters, granting bursts of up to MAX_BURST beats and stalling on wfull.
// Optional burst watchdog enabled by defining FIFO_WR_ARB_WATCHDOG_EN.
module fifo_wr_arb #(
   parameter int unsigned  NREQ      = 4,
   parameter int unsigned  DSIZE     = 8,
   parameter int unsigned  MAX_BURST = 4,
   localparam int unsigned IDW       = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_last,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  wfull,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy,
   output logic                  abort
);

   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                     state_q, state_d;
   logic [IDW-1:0]             owner_q, owner_d;
   logic [IDW-1:0]             last_q, last_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [IDW-1:0]             pick;
   logic                       found;
   logic [NREQ-1:0][DSIZE-1:0] data_arr;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
   logic [3:0]                 idle_q, idle_d;
   logic                       abort_q, abort_d;
`endif

   assign data_arr = req_data;

   // Round-robin search: first valid requester after the last grant, wrapping.
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      pick  = last_q;
      idx   = 0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx = (32'(last_q) + i) % NREQ;
         if (!found && req_valid[IDW'(idx)]) begin
            found = 1'b1;
            pick  = IDW'(idx);
         end
      end
   end

   // Next-state and write-port control.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      req_ready = '0;
      winc      = 1'b0;
      wdata     = '0;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
      idle_d    = idle_q;
      abort_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef FIFO_WR_ARB_WATCHDOG_EN
            idle_d = '0;
`endif
            if (found) begin
               owner_d = pick;
               last_d  = pick;
               cnt_d   = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            req_ready[owner_q] = !wfull;
            winc               = req_valid[owner_q] & !wfull;
            wdata              = data_arr[owner_q];
            if (winc) begin
               cnt_d = cnt_q + CW'(1);
               if (req_last[owner_q] || (cnt_q == CW'(MAX_BURST - 1))) begin
                  state_d = IDLE;
               end
            end
`ifdef FIFO_WR_ARB_WATCHDOG_EN
            // Owner gone quiet with room in the FIFO: count toward abort.
            if (winc) begin
               idle_d = '0;
            end else if (!req_valid[owner_q] && !wfull) begin
               if (idle_q == 4'd14) begin
                  idle_d  = '0;
                  abort_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  idle_d = idle_q + 4'd1;
               end
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= IDW'(NREQ - 1);
         cnt_q   <= '0;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
         idle_q  <= '0;
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
         idle_q  <= idle_d;
         abort_q <= abort_d;
`endif
      end
   end

   assign busy     = (state_q == BURST);
   assign grant_id = owner_q;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
   assign abort    = abort_q;
`else
   assign abort    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb: requester agents with per-requester beat queues,
// a transaction-level arbitration model feeding a scoreboard, and a monitor.
module tb_fifo_wr_arb;

   localparam int NREQ  = 4;
   localparam int DSIZE = 8;
   localparam int MAXB  = 4;
   localparam int IDW   = 2;
   localparam int DEPTH = 128;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_last;
   logic [NREQ-1:0][DSIZE-1:0] req_data_a;
   logic [NREQ*DSIZE-1:0]      req_data;
   logic [NREQ-1:0]            req_ready;
   logic                       wfull;
   logic                       winc;
   logic [DSIZE-1:0]           wdata;
   logic [IDW-1:0]             grant_id;
   logic                       busy;
   logic                       abort;

   assign req_data = req_data_a;

   fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
      .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
      .wdata(wdata), .grant_id(grant_id), .busy(busy), .abort(abort)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [7:0] data;
      bit         ab;
   } exp_t;

   logic [7:0] rq_data [NREQ][DEPTH];
   bit         rq_last [NREQ][DEPTH];
   int         rq_wr [NREQ];
   int         rq_rd [NREQ];
   exp_t       expq [$];

   int checks = 0;
   int failures = 0;
   int m_last = NREQ - 1;
   int scn_cyc = 0;
   int scn_beats = 0;
   int last_beat_cyc = -1;
   int abort_due = -100;
   logic [NREQ-1:0] hs_mask = '0;
   int wmode = 0;
   bit gaps_en = 1'b0;
   int stall_left = 0;
   bit stall_done = 1'b0;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Arbitration model: round-robin over requesters with pending beats; a
   // burst ends on last, on MAX beats, or (watchdog) when the owner runs dry.
   task automatic build_expect(output int cyc);
      int rd [NREQ];
      bit any, fnd, lst;
      int pick, n;
      exp_t e;
      for (int i = 0; i < NREQ; i++) rd[i] = rq_rd[i];
      cyc = 0;
      while (1) begin
         any = 1'b0;
         for (int i = 0; i < NREQ; i++) if (rd[i] < rq_wr[i]) any = 1'b1;
         if (!any) break;
         fnd = 1'b0;
         pick = 0;
         for (int k = 1; k <= NREQ; k++) begin
            if (!fnd && rd[(m_last + k) % NREQ] < rq_wr[(m_last + k) % NREQ]) begin
               fnd = 1'b1;
               pick = (m_last + k) % NREQ;
            end
         end
         m_last = pick;
         cyc += 1;
         n = 0;
         while (1) begin
            e.id = pick;
            e.data = rq_data[pick][rd[pick]];
            lst = rq_last[pick][rd[pick]];
            rd[pick]++;
            n++;
            cyc++;
            e.ab = !lst && (n < MAXB) && (rd[pick] == rq_wr[pick]);
            expq.push_back(e);
            if (lst || n == MAXB) break;
            if (e.ab) begin
               cyc += 15;
               break;
            end
         end
      end
   endtask

   task automatic load(input int id, input int n, input int base, input int lmode);
      for (int k = 0; k < n; k++) begin
         rq_data[id][rq_wr[id]] = 8'(base + k);
         rq_last[id][rq_wr[id]] = (lmode == 2) || (lmode == 0 && k == n - 1);
         rq_wr[id]++;
      end
   endtask

   task automatic sync();
      @(negedge clk);
      #1;
   endtask

   task automatic start_scn(output int exp_cyc);
      build_expect(exp_cyc);
      scn_cyc = -1;
      scn_beats = 0;
      last_beat_cyc = -1;
      abort_due = -100;
      stall_done = 1'b0;
      stall_left = 0;
   endtask

   task automatic run(input int mode, input bit gap, input bit chk_cyc,
                      input int stall_extra, input string nm);
      int exp_cyc;
      int guard;
      start_scn(exp_cyc);
      wmode = mode;
      gaps_en = gap;
      guard = 0;
      while (expq.size() != 0 && guard < 3000) begin
         @(posedge clk);
         guard++;
      end
      chk(expq.size() == 0, {"drain_", nm}, expq.size(), 0);
      if (chk_cyc)
         chk(last_beat_cyc == exp_cyc - 1 + stall_extra, {"cycles_", nm},
             last_beat_cyc, exp_cyc - 1 + stall_extra);
      wmode = 0;
      gaps_en = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      chk(busy == 1'b0, {"idle_after_", nm}, int'(busy), 0);
      for (int i = 0; i < NREQ; i++) begin
         chk(rq_rd[i] == rq_wr[i], {"consumed_", nm}, rq_rd[i], rq_wr[i]);
         rq_rd[i] = 0;
         rq_wr[i] = 0;
      end
      expq.delete();
   endtask

   // Requester agents and FIFO-full driver, updated just after each rising edge.
   initial begin
      bit gap;
      req_valid = '0;
      req_last = '0;
      req_data_a = '0;
      wfull = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         rq_rd[i] = 0;
         rq_wr[i] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++)
            if (hs_mask[i] && rq_rd[i] < rq_wr[i]) rq_rd[i]++;
         case (wmode)
            1: wfull = ($urandom_range(0, 3) == 0);
            2: begin
               if (stall_left > 0) begin
                  wfull = 1'b1;
                  stall_left--;
               end else if (!stall_done && scn_beats == 2) begin
                  wfull = 1'b1;
                  stall_left = 2;
                  stall_done = 1'b1;
               end else begin
                  wfull = 1'b0;
               end
            end
            default: wfull = 1'b0;
         endcase
         for (int i = 0; i < NREQ; i++) begin
            gap = gaps_en && busy && (int'(grant_id) == i) && ($urandom_range(0, 2) == 0);
            if (rq_rd[i] < rq_wr[i] && !gap) begin
               req_valid[i] = 1'b1;
               req_last[i] = rq_last[i][rq_rd[i]];
               req_data_a[i] = rq_data[i][rq_rd[i]];
            end else begin
               req_valid[i] = 1'b0;
               req_last[i] = 1'(($urandom_range(0, 1)));
               req_data_a[i] = 8'($urandom_range(0, 255));
            end
         end
      end
   end

   // Monitor: scoreboard on every write plus port invariants, at the falling edge.
   initial begin
      exp_t e;
      logic [NREQ-1:0] er;
      forever begin
         @(negedge clk);
         scn_cyc++;
         hs_mask = req_ready & req_valid;
         if (!rst) begin
            er = '0;
            if (busy && !wfull) er[grant_id] = 1'b1;
            chk(req_ready == er, "ready_rule", int'(req_ready), int'(er));
            chk(abort == (scn_cyc == abort_due), "abort", int'(abort), int'(scn_cyc == abort_due));
            if (wfull) chk(winc == 1'b0, "write_while_full", int'(winc), 0);
            if (busy && !winc)
               chk(wdata == req_data_a[grant_id], "wdata_hold", int'(wdata), int'(req_data_a[grant_id]));
            if (winc) begin
               chk(busy == 1'b1, "busy_on_write", int'(busy), 1);
               if (expq.size() == 0) begin
                  chk(1'b0, "unexpected_write", int'(wdata), -1);
               end else begin
                  e = expq.pop_front();
                  chk(int'(grant_id) == e.id, "grant_id", int'(grant_id), e.id);
                  chk(wdata == e.data, "wdata", int'(wdata), int'(e.data));
                  scn_beats++;
                  last_beat_cyc = scn_cyc;
                  if (e.ab) abort_due = scn_cyc + 16;
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout actual=1 required=0");
      $fatal(1, "timeout");
   end

   initial begin
      int dummy;
      int guard;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(busy == 1'b0, "rst_busy", int'(busy), 0);
      chk(winc == 1'b0, "rst_winc", int'(winc), 0);
      chk(grant_id == '0, "rst_grant_id", int'(grant_id), 0);
      chk(abort == 1'b0, "rst_abort", int'(abort), 0);
      chk(req_ready == '0, "rst_ready", int'(req_ready), 0);
      #1;
      rst = 1'b0;
      m_last = NREQ - 1;

      // Single requester, 4-beat burst A0..A3.
      sync();
      load(0, 4, 8'hA0, 0);
      run(0, 1'b0, 1'b1, 0, "single");

      // Round-robin: all requesters with two one-beat bursts each.
      sync();
      for (int i = 0; i < NREQ; i++) load(i, 2, 16 * (i + 1), 2);
      run(0, 1'b0, 1'b1, 0, "rr");

      // Burst cap: requester 2 never asserts last.
      sync();
      load(2, 8, 8'hC0, 1);
      run(0, 1'b0, 1'b1, 0, "cap");

      // Full stall for 3 cycles after beat 2.
      sync();
      load(1, 4, 8'h40, 0);
      run(2, 1'b0, 1'b1, 3, "stall");

      // Randomized traffic: bursts of 1..6 beats.
      for (int r = 0; r < 8; r++) begin
         sync();
         for (int i = 0; i < NREQ; i++) begin
            int nb;
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) load(i, $urandom_range(1, 6), $urandom_range(0, 255), 0);
         end
`ifdef FIFO_WR_ARB_WATCHDOG_EN
         run(r % 2, 1'b0, (r % 2) == 0, 0, "random");
`else
         run(r % 2, (r % 2) == 1, (r % 2) == 0, 0, "random");
`endif
      end

      // Reset asserted after beat 1 of requester 1.
      sync();
      load(1, 4, 8'h70, 0);
      start_scn(dummy);
      guard = 0;
      while (scn_beats < 1 && guard < 50) begin
         @(posedge clk);
         #2;
         guard++;
      end
      chk(scn_beats >= 1, "rst_mid_first_beat", scn_beats, 1);
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         rq_rd[i] = 0;
         rq_wr[i] = 0;
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      chk(busy == 1'b0, "rst_mid_busy", int'(busy), 0);
      chk(winc == 1'b0, "rst_mid_winc", int'(winc), 0);
      chk(grant_id == '0, "rst_mid_grant_id", int'(grant_id), 0);
      expq.delete();
      m_last = NREQ - 1;
      repeat (2) @(posedge clk);
      sync();
      load(1, 2, 8'h81, 0);
      load(0, 2, 8'h91, 0);
      run(0, 1'b0, 1'b1, 0, "after_rst");

`ifdef FIFO_WR_ARB_WATCHDOG_EN
      // Owner 2 stops after one beat without last; requester 3 is waiting.
      sync();
      load(2, 1, 8'h5A, 1);
      load(3, 1, 8'h6B, 0);
      run(0, 1'b0, 1'b1, 0, "watchdog");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin arbiter that shares the single write port of a FIFO among NREQ requesters.
- Grants one requester a burst of up to MAX_BURST beats and drives the FIFO winc/wdata.
- Stalls on the FIFO full flag.
- Sits in the write clock domain, directly in front of the FIFO write side.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 8, data word width.
- MAX_BURST, 4, maximum beats per grant (1..16).
- IDW, $clog2(NREQ), requester index width (derived; do not override).

Ports:
- clk  in  1  write-domain clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester data valid.
- req_last  in  NREQ  per-requester end-of-burst marker, qualified by valid.
- req_data  in  NREQ*DSIZE  packed data; requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready  out  NREQ  per-requester beat accept (one-hot or zero).
- wfull  in  1  FIFO full flag.
- winc  out  1  FIFO write enable.
- wdata  out  DSIZE  FIFO write data.
- grant_id  out  IDW  current owner index.
- busy  out  1  burst in progress.
- abort  out  1  watchdog abort pulse (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, owner = 0, beat count = 0.
  - RR pointer last = NREQ-1, so requester 0 has first priority.
  - busy = 0, grant_id = 0, abort = 0.
  - req_ready = 0, winc = 0.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from last+1 upward, wrapping modulo NREQ.
  - Register it as owner and set last = owner. Next state is BURST with beat count = 0.
  - Data valid in the IDLE cycle is not accepted. The grant costs exactly one bubble cycle.
- BURST:
  - req_ready[owner] = !wfull; all other ready bits = 0.
  - winc = req_valid[owner] & !wfull (combinational).
  - wdata = owner's data slice whenever busy, including when winc = 0.
  - A beat occurs when winc = 1; beat count increments on each beat.
- Burst end:
  - Ends on a beat with req_last[owner] = 1, or on the beat that makes the count equal MAX_BURST.
  - Next state is IDLE, so there is always one idle cycle between bursts.
- busy = (state == BURST). grant_id = owner while busy, otherwise holds its last value.
- Full flag:
  - wfull = 1 forces winc = 0 and ready = 0. The burst holds; the count does not advance.
  - wfull is sampled in the same cycle; no write may occur while wfull = 1.
- Owner drops valid mid-burst: burst is held, no beat, no timeout (base build).
- Requests from non-owners during a burst are ignored. They are considered at the next IDLE, in RR order after the owner.
- RR wrap: last = NREQ-1 searches from 0.
- Single requester: the same requester may be re-granted after its IDLE bubble.
- Reset asserted mid-burst: next edge returns to IDLE/reset values. The partial burst is abandoned with no further winc.
- Throughput: MAX_BURST beats in MAX_BURST+1 cycles when never full.

Optional Feature:
- Macro: FIFO_WR_ARB_WATCHDOG_EN.
- When defined:
  - A 4-bit idle counter runs in BURST and increments on each cycle with req_valid[owner] = 0 and wfull = 0.
  - The counter clears on any beat.
  - When it reaches 15, abort pulses 1 for one cycle and the state returns to IDLE. The burst ends without a last beat.
  - A full-stalled burst never times out.
- When undefined: abort is tied to 0 and bursts wait indefinitely.

Test Plan:
- Single requester:
  - Stimulus: after reset, req_valid = 4'b0001, data 0xA0..0xA3, req_last on the 4th beat, wfull = 0.
  - Response: busy rises one cycle after valid; winc high for 4 consecutive cycles, wdata A0,A1,A2,A3; busy falls; grant_id = 0.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously valid, 1-beat bursts (last always 1).
  - Response: grant order 0,1,2,3,0,1; one bubble between grants; 2 writes per 4 cycles.
- MAX_BURST cap:
  - Stimulus: requester 2 valid with req_last never asserted.
  - Response: exactly 4 beats, then IDLE, then re-grant to 2 (sole requester); no beat in the IDLE cycle.
- Full stall:
  - Stimulus: wfull held 1 for 3 cycles mid-burst after beat 2.
  - Response: winc = 0 and req_ready = 0 for those 3 cycles; beats 3 and 4 follow on release; total beats = 4, none lost or duplicated.
- Reset mid-burst:
  - Stimulus: assert rst for 1 cycle after beat 1 of requester 1.
  - Response: next cycle busy = 0 and winc = 0; next grant goes to requester 0 if valid.
- Watchdog (FIFO_WR_ARB_WATCHDOG_EN):
  - Stimulus: owner drops valid after beat 1, wfull = 0.
  - Response: abort pulse 15 cycles later; state IDLE; another waiting requester granted next.
